// File: rtl/frame_drawer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_drawer_pkg
// Description : State encoding and default geometry shared by the frame drawer.
// Revision    : 1.0
// ============================================================================
package frame_drawer_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] S_SQ_ERASE  = 3'd1;
   localparam logic [STATE_W-1:0] S_SQ_DRAW   = 3'd2;
   localparam logic [STATE_W-1:0] S_SQ_DONE   = 3'd3;
   localparam logic [STATE_W-1:0] S_CAT_ERASE = 3'd4;
   localparam logic [STATE_W-1:0] S_CAT_DRAW  = 3'd5;
   localparam logic [STATE_W-1:0] S_CAT_DONE  = 3'd6;

   localparam int c_num_squares = 4;
   localparam int c_sq_size     = 4;
   localparam int c_catcher_w   = 16;
   localparam int c_catcher_h   = 2;
   localparam int c_x_w         = 8;
   localparam int c_y_w         = 7;
   localparam int c_colour_w    = 3;
   localparam int c_bg_colour   = 0;

   // Counter width for 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rect_scanner.sv
`default_nettype none
// ============================================================================
// Module      : rect_scanner
// Description : Raster walker over a W x H rectangle, px inner and py outer.
// Revision    : 1.0
// ============================================================================
module rect_scanner
   import frame_drawer_pkg::*;
#(
   parameter int W    = 4,
   parameter int H    = 4,
   parameter int PX_W = cnt_width(W),
   parameter int PY_W = cnt_width(H)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            step,
   output logic [PX_W-1:0] px,
   output logic [PY_W-1:0] py,
   output logic            last
);

   logic [PX_W-1:0] r_px;
   logic [PY_W-1:0] r_py;
   logic            w_px_end;
   logic            w_py_end;

   assign w_px_end = (r_px == PX_W'(W - 1));
   assign w_py_end = (r_py == PY_W'(H - 1));

   // Stepping on the last pixel wraps back to the origin for the next rectangle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_px <= '0;
         r_py <= '0;
      end else if (clear) begin
         r_px <= '0;
         r_py <= '0;
      end else if (step) begin
         if (w_px_end) begin
            r_px <= '0;
            r_py <= w_py_end ? '0 : r_py + 1'b1;
         end else begin
            r_px <= r_px + 1'b1;
         end
      end
   end

   assign px   = r_px;
   assign py   = r_py;
   assign last = w_px_end & w_py_end;

endmodule
`default_nettype wire

// File: rtl/frame_drawer.sv
`default_nettype none
// ============================================================================
// Module      : frame_drawer
// Description : Erase-then-redraw pixel generator for falling squares and catcher.
// Revision    : 1.0
// ============================================================================
module frame_drawer
   import frame_drawer_pkg::*;
#(
   parameter int NUM_SQUARES = c_num_squares,
   parameter int SQ_SIZE     = c_sq_size,
   parameter int CATCHER_W   = c_catcher_w,
   parameter int CATCHER_H   = c_catcher_h,
   parameter int X_W         = c_x_w,
   parameter int Y_W         = c_y_w,
   parameter int COLOUR_W    = c_colour_w,
   parameter int BG_COLOUR   = c_bg_colour
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            draw_squares,
   input  logic                            draw_catcher,
   input  logic [NUM_SQUARES*X_W-1:0]      squares_x,
   input  logic [NUM_SQUARES*Y_W-1:0]      squares_y,
   input  logic [NUM_SQUARES*COLOUR_W-1:0] squares_colour,
   input  logic [X_W-1:0]                  catcher_x,
   input  logic [Y_W-1:0]                  catcher_y,
   input  logic [COLOUR_W-1:0]             catcher_colour,
   output logic [X_W-1:0]                  x,
   output logic [Y_W-1:0]                  y,
   output logic [COLOUR_W-1:0]             colour,
   output logic                            vga_write,
   output logic                            finish_drawing_squares,
   output logic                            finish_drawing_catcher
);

   localparam int IDX_W = cnt_width(NUM_SQUARES);
   localparam int SQ_PW = cnt_width(SQ_SIZE);
   localparam int CX_PW = cnt_width(CATCHER_W);
   localparam int CY_PW = cnt_width(CATCHER_H);

   logic [STATE_W-1:0]              r_state;
   logic [STATE_W-1:0]              w_next_state;
   logic [IDX_W-1:0]                r_idx;
   logic [NUM_SQUARES*X_W-1:0]      r_cur_sx, r_prev_sx;
   logic [NUM_SQUARES*Y_W-1:0]      r_cur_sy, r_prev_sy;
   logic [NUM_SQUARES*COLOUR_W-1:0] r_cur_sc;
   logic                            r_sq_prev_valid;
   logic [X_W-1:0]                  r_cur_cx, r_prev_cx;
   logic [Y_W-1:0]                  r_cur_cy, r_prev_cy;
   logic [COLOUR_W-1:0]             r_cur_cc;
   logic                            r_cat_prev_valid;

   logic             w_sq_scan, w_cat_scan;
   logic [SQ_PW-1:0] w_sq_px, w_sq_py;
   logic [CX_PW-1:0] w_cat_px;
   logic [CY_PW-1:0] w_cat_py;
   logic             w_sq_last, w_cat_last;
   logic             w_sq_idx_end, w_sq_pass_end;

   assign w_sq_scan     = (r_state == S_SQ_ERASE) || (r_state == S_SQ_DRAW);
   assign w_cat_scan    = (r_state == S_CAT_ERASE) || (r_state == S_CAT_DRAW);
   assign w_sq_idx_end  = (r_idx == IDX_W'(NUM_SQUARES - 1));
   assign w_sq_pass_end = w_sq_last && w_sq_idx_end;

   rect_scanner #(.W(SQ_SIZE), .H(SQ_SIZE)) u_sq_scanner (
      .clock (clock),
      .reset (reset),
      .clear (~w_sq_scan),
      .step  (w_sq_scan),
      .px    (w_sq_px),
      .py    (w_sq_py),
      .last  (w_sq_last)
   );

   rect_scanner #(.W(CATCHER_W), .H(CATCHER_H)) u_cat_scanner (
      .clock (clock),
      .reset (reset),
      .clear (~w_cat_scan),
      .step  (w_cat_scan),
      .px    (w_cat_px),
      .py    (w_cat_py),
      .last  (w_cat_last)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Squares win a tie; a still-high catcher request is taken on the next IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (draw_squares)      w_next_state = r_sq_prev_valid ? S_SQ_ERASE : S_SQ_DRAW;
            else if (draw_catcher) w_next_state = r_cat_prev_valid ? S_CAT_ERASE : S_CAT_DRAW;
         end
         S_SQ_ERASE:  if (w_sq_pass_end) w_next_state = S_SQ_DRAW;
         S_SQ_DRAW:   if (w_sq_pass_end) w_next_state = S_SQ_DONE;
         S_SQ_DONE:   if (!draw_squares) w_next_state = S_IDLE;
         S_CAT_ERASE: if (w_cat_last)    w_next_state = S_CAT_DRAW;
         S_CAT_DRAW:  if (w_cat_last)    w_next_state = S_CAT_DONE;
         S_CAT_DONE:  if (!draw_catcher) w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_idx            <= '0;
         r_cur_sx         <= '0;
         r_cur_sy         <= '0;
         r_cur_sc         <= '0;
         r_prev_sx        <= '0;
         r_prev_sy        <= '0;
         r_sq_prev_valid  <= 1'b0;
         r_cur_cx         <= '0;
         r_cur_cy         <= '0;
         r_cur_cc         <= '0;
         r_prev_cx        <= '0;
         r_prev_cy        <= '0;
         r_cat_prev_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_idx <= '0;
               if (draw_squares) begin
                  r_cur_sx <= squares_x;
                  r_cur_sy <= squares_y;
                  r_cur_sc <= squares_colour;
               end else if (draw_catcher) begin
                  r_cur_cx <= catcher_x;
                  r_cur_cy <= catcher_y;
                  r_cur_cc <= catcher_colour;
               end
            end
            S_SQ_ERASE, S_SQ_DRAW: begin
               if (w_sq_last) r_idx <= w_sq_idx_end ? '0 : r_idx + 1'b1;
               if ((r_state == S_SQ_DRAW) && w_sq_pass_end) begin
                  r_prev_sx       <= r_cur_sx;
                  r_prev_sy       <= r_cur_sy;
                  r_sq_prev_valid <= 1'b1;
               end
            end
            S_CAT_DRAW: begin
               if (w_cat_last) begin
                  r_prev_cx        <= r_cur_cx;
                  r_prev_cy        <= r_cur_cy;
                  r_cat_prev_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Coordinates wrap modulo the bus width; nothing is clipped.
   always_comb begin
      x                      = '0;
      y                      = '0;
      colour                 = '0;
      vga_write              = 1'b0;
      finish_drawing_squares = 1'b0;
      finish_drawing_catcher = 1'b0;
      case (r_state)
         S_SQ_ERASE: begin
            vga_write = 1'b1;
            x         = r_prev_sx[r_idx*X_W +: X_W] + X_W'(w_sq_px);
            y         = r_prev_sy[r_idx*Y_W +: Y_W] + Y_W'(w_sq_py);
            colour    = COLOUR_W'(BG_COLOUR);
         end
         S_SQ_DRAW: begin
            vga_write = 1'b1;
            x         = r_cur_sx[r_idx*X_W +: X_W] + X_W'(w_sq_px);
            y         = r_cur_sy[r_idx*Y_W +: Y_W] + Y_W'(w_sq_py);
            colour    = r_cur_sc[r_idx*COLOUR_W +: COLOUR_W];
         end
         S_CAT_ERASE: begin
            vga_write = 1'b1;
            x         = r_prev_cx + X_W'(w_cat_px);
            y         = r_prev_cy + Y_W'(w_cat_py);
            colour    = COLOUR_W'(BG_COLOUR);
         end
         S_CAT_DRAW: begin
            vga_write = 1'b1;
            x         = r_cur_cx + X_W'(w_cat_px);
            y         = r_cur_cy + Y_W'(w_cat_py);
            colour    = r_cur_cc;
         end
         S_SQ_DONE:  finish_drawing_squares = 1'b1;
         S_CAT_DONE: finish_drawing_catcher = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_drawer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_drawer
// Description : Self-checking bench for frame_drawer against a pixel-list model.
// Revision    : 1.0
// ============================================================================
module tb_frame_drawer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        draw_squares = 1'b0;
   logic        draw_catcher = 1'b0;
   logic [31:0] squares_x = '0;
   logic [27:0] squares_y = '0;
   logic [11:0] squares_colour = '0;
   logic [7:0]  catcher_x = '0;
   logic [6:0]  catcher_y = '0;
   logic [2:0]  catcher_colour = '0;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        vga_write;
   logic        finish_drawing_squares;
   logic        finish_drawing_catcher;

   frame_drawer dut (
      .clock                  (clock),
      .reset                  (reset),
      .draw_squares           (draw_squares),
      .draw_catcher           (draw_catcher),
      .squares_x              (squares_x),
      .squares_y              (squares_y),
      .squares_colour         (squares_colour),
      .catcher_x              (catcher_x),
      .catcher_y              (catcher_y),
      .catcher_colour         (catcher_colour),
      .x                      (x),
      .y                      (y),
      .colour                 (colour),
      .vga_write              (vga_write),
      .finish_drawing_squares (finish_drawing_squares),
      .finish_drawing_catcher (finish_drawing_catcher)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   typedef struct {
      logic [31:0] sx;
      logic [27:0] sy;
      logic [11:0] col;
      int          exp_writes;
      logic [17:0] first_pix;
      int          hold;
   } sq_vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   pix_t exp_q[$];
   int   m_sq_x[4];
   int   m_sq_y[4];
   bit   m_sq_valid  = 1'b0;
   int   m_cat_x     = 0;
   int   m_cat_y     = 0;
   bit   m_cat_valid = 1'b0;
   int   r_nwrites;
   logic [17:0] r_first_pix, r_last_pix;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference model: every pixel of a rectangle, row by row, wrapped modulo 256/128.
   function automatic void push_rect(input int bx, input int by, input int w, input int h, input int c);
      pix_t p;
      for (int j = 0; j < h; j++)
         for (int i = 0; i < w; i++) begin
            p.px = 8'((bx + i) % 256);
            p.py = 7'((by + j) % 128);
            p.pc = 3'(c);
            exp_q.push_back(p);
         end
   endfunction

   function automatic void model_sq(input logic [31:0] sx, input logic [27:0] sy, input logic [11:0] col);
      if (m_sq_valid)
         for (int i = 0; i < 4; i++) push_rect(m_sq_x[i], m_sq_y[i], 4, 4, 0);
      for (int i = 0; i < 4; i++) begin
         push_rect(int'(sx[i*8 +: 8]), int'(sy[i*7 +: 7]), 4, 4, int'(col[i*3 +: 3]));
         m_sq_x[i] = int'(sx[i*8 +: 8]);
         m_sq_y[i] = int'(sy[i*7 +: 7]);
      end
      m_sq_valid = 1'b1;
   endfunction

   function automatic void model_cat(input logic [7:0] cx, input logic [6:0] cy, input logic [2:0] cc);
      if (m_cat_valid) push_rect(m_cat_x, m_cat_y, 16, 2, 0);
      push_rect(int'(cx), int'(cy), 16, 2, int'(cc));
      m_cat_x     = int'(cx);
      m_cat_y     = int'(cy);
      m_cat_valid = 1'b1;
   endfunction

   // Runs one pass to its finish flag, comparing every write against the model list.
   task automatic collect(input bit is_sq, input int budget);
      int   exp_n;
      bit   done;
      logic fin;
      pix_t e;
      exp_n     = exp_q.size();
      done      = 1'b0;
      r_nwrites = 0;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         @(negedge clock);
         if (cyc == 0) chk("first_pixel_latency", vga_write, 1);
         if (vga_write) begin
            if (exp_q.size() == 0) chk("extra_write", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("pixel", {x, y, colour}, e);
            end
            if (r_nwrites == 0) r_first_pix = {x, y, colour};
            r_last_pix = {x, y, colour};
            r_nwrites++;
         end
         fin = is_sq ? finish_drawing_squares : finish_drawing_catcher;
         if (fin) begin
            done = 1'b1;
            chk("finish_without_write", vga_write, 0);
         end
      end
      if (!done) chk("pass_timeout", 0, 1);
      chk("write_count", r_nwrites, exp_n);
      exp_q.delete();
   endtask

   task automatic end_pass(input bit is_sq, input int hold);
      repeat (hold) begin
         @(negedge clock);
         chk("done_hold_finish", is_sq ? finish_drawing_squares : finish_drawing_catcher, 1);
         chk("done_hold_no_write", vga_write, 0);
      end
      if (is_sq) draw_squares = 1'b0;
      else       draw_catcher = 1'b0;
      @(negedge clock);
      chk("done_exit_finish", is_sq ? finish_drawing_squares : finish_drawing_catcher, 0);
      chk("done_exit_no_write", vga_write, 0);
   endtask

   task automatic sq_pass(input logic [31:0] sx, input logic [27:0] sy, input logic [11:0] col, input int hold);
      squares_x      = sx;
      squares_y      = sy;
      squares_colour = col;
      model_sq(sx, sy, col);
      draw_squares = 1'b1;
      collect(1'b1, 1000);
      end_pass(1'b1, hold);
   endtask

   task automatic cat_pass(input logic [7:0] cx, input logic [6:0] cy, input logic [2:0] cc, input int hold);
      catcher_x      = cx;
      catcher_y      = cy;
      catcher_colour = cc;
      model_cat(cx, cy, cc);
      draw_catcher = 1'b1;
      collect(1'b0, 1000);
      end_pass(1'b0, hold);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_x"}, x, 0);
      chk({name, "_y"}, y, 0);
      chk({name, "_colour"}, colour, 0);
      chk({name, "_vga_write"}, vga_write, 0);
      chk({name, "_finish_sq"}, finish_drawing_squares, 0);
      chk({name, "_finish_cat"}, finish_drawing_catcher, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   sq_vec_t vecs[3];

   initial begin
      int   n;
      pix_t e;

      vecs[0] = '{sx: {8'd100, 8'd0, 8'd30, 8'd10}, sy: {7'd50, 7'd0, 7'd5, 7'd20},
                  col: {3'd4, 3'd3, 3'd2, 3'd1}, exp_writes: 64,
                  first_pix: {8'd10, 7'd20, 3'd1}, hold: 0};
      vecs[1] = '{sx: {8'd100, 8'd0, 8'd30, 8'd10}, sy: {7'd50, 7'd0, 7'd5, 7'd21},
                  col: {3'd4, 3'd3, 3'd2, 3'd1}, exp_writes: 128,
                  first_pix: {8'd10, 7'd20, 3'd0}, hold: 5};
      vecs[2] = '{sx: {8'd7, 8'd200, 8'd60, 8'd254}, sy: {7'd100, 7'd3, 7'd60, 7'd126},
                  col: {3'd2, 3'd7, 3'd6, 3'd5}, exp_writes: 128,
                  first_pix: {8'd10, 7'd21, 3'd0}, hold: 1};

      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("idle");

      for (int v = 0; v < 3; v++) begin
         sq_pass(vecs[v].sx, vecs[v].sy, vecs[v].col, vecs[v].hold);
         chk("vec_writes", r_nwrites, vecs[v].exp_writes);
         chk("vec_first_pixel", r_first_pix, vecs[v].first_pix);
      end

      cat_pass(8'd120, 7'd118, 3'd7, 0);
      chk("cat1_writes", r_nwrites, 32);
      chk("cat1_first", r_first_pix, {8'd120, 7'd118, 3'd7});
      chk("cat1_last", r_last_pix, {8'd135, 7'd119, 3'd7});

      cat_pass(8'd250, 7'd127, 3'd5, 2);
      chk("cat2_writes", r_nwrites, 64);
      chk("cat2_first_erase", r_first_pix, {8'd120, 7'd118, 3'd0});
      chk("cat2_last_wrapped", r_last_pix, {8'd9, 7'd0, 3'd5});

      // Both requests together: squares first, one IDLE cycle, then catcher.
      squares_x      = $urandom;
      squares_y      = 28'($urandom);
      squares_colour = 12'($urandom);
      catcher_x      = 8'($urandom);
      catcher_y      = 7'($urandom);
      catcher_colour = 3'($urandom);
      model_sq(squares_x, squares_y, squares_colour);
      draw_squares = 1'b1;
      draw_catcher = 1'b1;
      collect(1'b1, 1000);
      chk("both_catcher_waiting", finish_drawing_catcher, 0);
      draw_squares = 1'b0;
      @(negedge clock);
      chk("both_gap_no_write", vga_write, 0);
      chk("both_gap_finish_sq", finish_drawing_squares, 0);
      model_cat(catcher_x, catcher_y, catcher_colour);
      collect(1'b0, 1000);
      chk("both_cat_writes", r_nwrites, 64);
      end_pass(1'b0, 0);

      // Reset at write 40 aborts the pass and forgets the previous positions.
      squares_x      = $urandom;
      squares_y      = 28'($urandom);
      squares_colour = 12'($urandom);
      model_sq(squares_x, squares_y, squares_colour);
      draw_squares = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 300 && n < 40; cyc++) begin
         @(negedge clock);
         if (vga_write) begin
            e = exp_q.pop_front();
            chk("pre_reset_pixel", {x, y, colour}, e);
            n++;
         end
      end
      chk("pre_reset_writes", n, 40);
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      draw_squares = 1'b0;
      exp_q.delete();
      m_sq_valid  = 1'b0;
      m_cat_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      sq_pass($urandom, 28'($urandom), 12'($urandom), 0);
      chk("post_reset_sq_draw_only", r_nwrites, 64);
      cat_pass(8'($urandom), 7'($urandom), 3'($urandom), 0);
      chk("post_reset_cat_draw_only", r_nwrites, 32);

      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 1) == 1)
            sq_pass($urandom, 28'($urandom), 12'($urandom), $urandom_range(0, 3));
         else
            cat_pass(8'($urandom), 7'($urandom), 3'($urandom), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
